// File: rtl/chip8_fb_responder.sv
// chip8_fb_responder: 256-byte framebuffer with a single-request processor port
// (plain read/write, XOR-draw with collision flag, clear-all) and an independent
// read-only video port. Both read paths have READ_LATENCY cycles of latency.
// Build option: define FB_RESET_CLEAR_EN to run an automatic, response-less clear
// of the whole framebuffer after every reset release.
module chip8_fb_responder #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [11:0] proc_addr_in,
    input  logic        proc_we_in,
    input  logic        proc_valid_in,
    input  logic [7:0]  proc_data_in,
    input  logic [1:0]  proc_type_in,
    output logic        proc_ready_out,
    output logic        proc_valid_out,
    output logic [7:0]  data_out,
    input  logic [7:0]  video_addr_in,
    output logic [7:0]  video_data_out
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, CLEAR, RESP} state_e;

    state_e     state_reg;
    logic [7:0] addr_reg;
    logic [7:0] operand_reg;
    logic [7:0] clr_cnt_reg;
    logic [2:0] wait_cnt_reg;
    logic [7:0] resp_data_reg;
    logic       resp_ram_reg;
    logic       ready_reg;
    logic       valid_reg;
`ifdef FB_RESET_CLEAR_EN
    logic       auto_clear_reg;
`endif

    logic [7:0] fb [256];
    logic [7:0] proc_pipe [READ_LATENCY];
    logic [7:0] video_pipe [READ_LATENCY];

    logic [7:0] port_addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] old_data;

    // Upper address nibble is deliberately ignored.
    wire unused_high_addr = &{1'b0, proc_addr_in[11:8]};

    // The processor read data of the latched address, READ_LATENCY cycles after it was sampled.
    assign old_data = proc_pipe[READ_LATENCY-1];

    // Processor-side port: one address shared by read and write, write gated off during reset.
    always_comb begin
        port_addr = addr_reg;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        case (state_reg)
            IDLE: begin
                port_addr = proc_addr_in[7:0];
                wr_en     = proc_valid_in && (proc_type_in == 2'b00) && proc_we_in;
                wr_data   = proc_data_in;
            end
            RMW_WR: begin
                wr_en   = 1'b1;
                wr_data = old_data ^ operand_reg;
            end
            CLEAR: begin
                port_addr = clr_cnt_reg;
                wr_en     = 1'b1;
            end
            default: ;
        endcase
        if (!rst_in) begin
            wr_en = 1'b0;
        end
    end

    // Framebuffer write plus read-first registered read on the processor port.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            fb[port_addr] <= wr_data;
        end
        proc_pipe[0] <= fb[port_addr];
        for (int i = 1; i < READ_LATENCY; i++) begin
            proc_pipe[i] <= proc_pipe[i-1];
        end
    end

    // Video port: read-first registered read, delayed to READ_LATENCY, cleared by reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                video_pipe[i] <= 8'h00;
            end
        end else begin
            video_pipe[0] <= fb[video_addr_in];
            for (int i = 1; i < READ_LATENCY; i++) begin
                video_pipe[i] <= video_pipe[i-1];
            end
        end
    end

    // Request sequencer with registered ready/valid and response data.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
`ifdef FB_RESET_CLEAR_EN
            state_reg      <= CLEAR;
            ready_reg      <= 1'b0;
            auto_clear_reg <= 1'b1;
`else
            state_reg      <= IDLE;
            ready_reg      <= 1'b1;
`endif
            valid_reg     <= 1'b0;
            resp_ram_reg  <= 1'b0;
            resp_data_reg <= 8'h00;
            clr_cnt_reg   <= 8'h00;
            wait_cnt_reg  <= 3'd0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (proc_valid_in) begin
                        addr_reg      <= proc_addr_in[7:0];
                        operand_reg   <= proc_data_in;
                        ready_reg     <= 1'b0;
                        resp_ram_reg  <= 1'b0;
                        resp_data_reg <= 8'h00;
                        wait_cnt_reg  <= 3'd1;
                        case (proc_type_in)
                            2'b00: begin
                                if (proc_we_in) begin
                                    state_reg <= RESP;
                                    valid_reg <= 1'b1;
                                end else begin
                                    resp_ram_reg <= 1'b1;
                                    if (READ_LATENCY == 1) begin
                                        state_reg <= RESP;
                                        valid_reg <= 1'b1;
                                    end else begin
                                        state_reg <= RD_WAIT;
                                    end
                                end
                            end
                            2'b01: begin
                                state_reg <= (READ_LATENCY == 1) ? RMW_WR : RMW_RD;
                            end
                            2'b10: begin
                                state_reg   <= CLEAR;
                                clr_cnt_reg <= 8'h00;
                            end
                            default: begin
                                state_reg <= RESP;
                                valid_reg <= 1'b1;
                            end
                        endcase
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt_reg == 3'(READ_LATENCY - 1)) begin
                        state_reg <= RESP;
                        valid_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 3'd1;
                    end
                end
                RMW_RD: begin
                    if (wait_cnt_reg == 3'(READ_LATENCY - 1)) begin
                        state_reg <= RMW_WR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 3'd1;
                    end
                end
                RMW_WR: begin
                    resp_data_reg <= {7'd0, |(old_data & operand_reg)};
                    state_reg     <= RESP;
                    valid_reg     <= 1'b1;
                end
                CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 8'd1;
                    if (clr_cnt_reg == 8'hFF) begin
`ifdef FB_RESET_CLEAR_EN
                        if (auto_clear_reg) begin
                            state_reg      <= IDLE;
                            ready_reg      <= 1'b1;
                            auto_clear_reg <= 1'b0;
                        end else begin
                            state_reg <= RESP;
                            valid_reg <= 1'b1;
                        end
`else
                        state_reg <= RESP;
                        valid_reg <= 1'b1;
`endif
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign proc_ready_out = ready_reg;
    assign proc_valid_out = valid_reg;
    assign data_out       = valid_reg ? (resp_ram_reg ? old_data : resp_data_reg) : 8'h00;
    assign video_data_out = video_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_chip8_fb_responder.sv
// Testbench for chip8_fb_responder in its default build (FB_RESET_CLEAR_EN undefined).
// A reference framebuffer is updated on the edges where the rules say bytes change;
// expected responses and video data go into queues checked by separate monitors.
module tb_chip8_fb_responder;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] proc_addr = 12'h000;
    logic        proc_we = 1'b0;
    logic        proc_valid = 1'b0;
    logic [7:0]  proc_data = 8'h00;
    logic [1:0]  proc_type = 2'b00;
    logic        proc_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [7:0]  video_addr = 8'h00;
    logic [7:0]  video_data;

    chip8_fb_responder #(.READ_LATENCY(L)) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .proc_addr_in  (proc_addr),
        .proc_we_in    (proc_we),
        .proc_valid_in (proc_valid),
        .proc_data_in  (proc_data),
        .proc_type_in  (proc_type),
        .proc_ready_out(proc_ready),
        .proc_valid_out(resp_valid),
        .data_out      (resp_data),
        .video_addr_in (video_addr),
        .video_data_out(video_data)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int due; logic [7:0] data; } resp_t;
    typedef struct { int at; logic [7:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int due; logic [7:0] data; bit known; } vid_t;

    resp_t      resp_q[$];
    wr_t        wr_q[$];
    vid_t       vid_q[$];
    logic [7:0] model [256];
    bit         known [256];

    int edge_n      = 0;
    int busy_until  = 0;
    int last_rst    = -1000;
    int last_accept = 0;
    bit armed       = 1'b0;
    int n_cmp       = 0;
    int n_bad       = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // Reference model: on each rising edge sample the video request, then apply due byte writes.
    initial begin
        vid_t v;
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            v.due   = edge_n + L - 1;
            v.data  = model[video_addr];
            v.known = known[video_addr];
            vid_q.push_back(v);
            if (!rst_n) begin
                wr_q.delete();
                resp_q.delete();
                busy_until = edge_n;
                last_rst   = edge_n;
                armed      = 1'b1;
            end else begin
                while (wr_q.size() > 0 && wr_q[0].at == edge_n) begin
                    model[wr_q[0].addr] = wr_q[0].data;
                    known[wr_q[0].addr] = 1'b1;
                    void'(wr_q.pop_front());
                end
            end
        end
    end

    // Monitor: compares DUT outputs with queued expectations on every falling edge.
    initial begin
        resp_t r;
        vid_t  v;
        bit    exp_v;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (edge_n == last_rst) begin
                    check("rst_valid", {31'd0, resp_valid}, 32'd0);
                    check("rst_data", {24'd0, resp_data}, 32'd0);
                    check("rst_video", {24'd0, video_data}, 32'd0);
                end
                check("ready", {31'd0, proc_ready}, {31'd0, (edge_n >= busy_until)});
                exp_v = (resp_q.size() > 0 && resp_q[0].due == edge_n);
                check("resp_valid", {31'd0, resp_valid}, {31'd0, exp_v});
                if (exp_v) begin
                    r = resp_q.pop_front();
                    if (resp_valid === 1'b1) begin
                        check("resp_data", {24'd0, resp_data}, {24'd0, r.data});
                    end
                end
            end
            while (vid_q.size() > 0 && vid_q[0].due < edge_n) begin
                void'(vid_q.pop_front());
            end
            if (vid_q.size() > 0 && vid_q[0].due == edge_n) begin
                v = vid_q.pop_front();
                if (armed && v.known && edge_n >= last_rst + L) begin
                    check("video_data", {24'd0, video_data}, {24'd0, v.data});
                end
            end
        end
    end

    // Random video addresses every cycle, fully independent of the processor traffic.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            video_addr = 8'($urandom);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Issue one request once the model says the block is idle; requests shown while busy are noise.
    task automatic issue(input logic [11:0] addr, input logic we, input logic [7:0] data,
                         input logic [1:0] typ);
        resp_t      r;
        wr_t        w;
        int         a;
        int         d;
        logic [7:0] idx;
        logic [7:0] old;
        while (edge_n < busy_until) begin
            proc_valid = 1'($urandom_range(0, 1));
            proc_addr  = 12'($urandom);
            proc_we    = 1'($urandom);
            proc_data  = 8'($urandom);
            proc_type  = 2'($urandom);
            step();
        end
        proc_valid = 1'b1;
        proc_addr  = addr;
        proc_we    = we;
        proc_data  = data;
        proc_type  = typ;
        a   = edge_n + 1;
        idx = addr[7:0];
        r.data = 8'h00;
        d = 1;
        case (typ)
            2'b00: begin
                if (we) begin
                    w.at = a; w.addr = idx; w.data = data;
                    wr_q.push_back(w);
                end else begin
                    d = L;
                    r.data = model[idx];
                end
            end
            2'b01: begin
                old = model[idx];
                w.at = a + L; w.addr = idx; w.data = old ^ data;
                wr_q.push_back(w);
                d = L + 1;
                r.data = ((old & data) != 8'h00) ? 8'h01 : 8'h00;
            end
            2'b10: begin
                for (int i = 0; i < 256; i++) begin
                    w.at = a + 1 + i; w.addr = 8'(i); w.data = 8'h00;
                    wr_q.push_back(w);
                end
                d = 257;
            end
            default: d = 1;
        endcase
        r.due = a + d - 1;
        resp_q.push_back(r);
        busy_until  = a + d;
        last_accept = a;
        $display("req edge %0d type %0d we %0d addr %03h data %02h -> expect %02h at edge %0d",
                 a, typ, we, addr, data, r.data, r.due);
        step();
        proc_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic fill(input logic [7:0] val, input bit rnd);
        for (int i = 0; i < 256; i++) begin
            issue({4'($urandom), 8'(i)}, 1'b1, rnd ? 8'($urandom) : val, 2'b00);
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 256; i++) begin
            issue({4'($urandom), 8'(i)}, 1'b0, 8'($urandom), 2'b00);
        end
    endtask

    initial begin
        int r;
        for (int i = 0; i < 256; i++) begin
            model[i] = 8'h00;
            known[i] = 1'b0;
        end
        repeat (3) step();
        rst_n = 1'b1;
        step();

        fill(8'h00, 1'b1);

        // write/read round trip
        issue(12'h012, 1'b1, 8'hA5, 2'b00);
        issue(12'h012, 1'b0, 8'h00, 2'b00);
        // XOR-draw collision flag, second XOR with we=0
        issue(12'h040, 1'b1, 8'hF0, 2'b00);
        issue(12'h040, 1'b1, 8'h3C, 2'b01);
        issue(12'h040, 1'b0, 8'h03, 2'b01);
        issue(12'h040, 1'b0, 8'h00, 2'b00);
        // high address bits ignored, reserved type is a no-op
        issue(12'hF12, 1'b1, 8'h5A, 2'b00);
        issue(12'h012, 1'b0, 8'h00, 2'b00);
        issue(12'hF12, 1'b1, 8'hC3, 2'b11);
        issue(12'h012, 1'b0, 8'h00, 2'b00);

        // full clear
        fill(8'hFF, 1'b0);
        issue(12'h000, 1'b0, 8'h00, 2'b10);
        read_all();

        // clear aborted by reset when byte 100 is due
        fill(8'hFF, 1'b0);
        issue(12'h000, 1'b0, 8'h00, 2'b10);
        while (edge_n < last_accept + 100) step();
        pulse_reset();
        read_all();

        // randomized traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                issue(12'($urandom), 1'($urandom), 8'($urandom), 2'b10);
            end else if (r <= 2) begin
                issue(12'($urandom), 1'($urandom), 8'($urandom), 2'b11);
            end else if (r <= 9) begin
                issue(12'($urandom), 1'($urandom), 8'($urandom), 2'b01);
            end else begin
                issue(12'($urandom), 1'($urandom), 8'($urandom), 2'b00);
            end
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(0, 3)) step();
                pulse_reset();
            end
        end

        while (edge_n < busy_until + L + 2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
